unidade_acesso_memoria: RTL
===========================

# unidade_acesso_memoria

Load/store initiator that drives the data RAM port (endereco, entrada, we, re, saida) on behalf of the processor datapath. Accepts one byte-addressed load or store at a time over a valid/ready handshake and converts it to word-indexed RAM cycles. Sub-word stores use read-modify-write; loads return the extracted, extended value over a second valid/ready handshake. Sits between the execute/memory stage and the data RAM.

## Interface
- PROFUNDIDADE, 1024: RAM depth in 32-bit words; word indices >= PROFUNDIDADE are out of range.
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valido  in  1  request present.
- req_pronto  out  1  unit can accept; high only in OCIOSO with rst_n high.
- req_escrita  in  1  1 = store, 0 = load.
- req_tamanho  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_sinal  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_endereco  in  32  byte address.
- req_dado  in  32  store data, right-aligned.
- resp_valido  out  1  response present.
- resp_pronto  in  1  consumer accepts response.
- resp_dado  out  32  load result; 0 for stores and errors.
- resp_erro  out  1  misaligned, illegal size, or out-of-range request.
- mem_endereco  out  32  word index {2'b0, req_endereco[31:2]}, to RAM endereco.
- mem_entrada  out  32  write word, to RAM entrada.
- mem_we / mem_re  out  1 each  to RAM we / re.
- mem_saida  in  32  RAM read data, combinational from mem_endereco while mem_re = 1.

## Operation
- States: OCIOSO, LEITURA, ESCRITA, RESPOSTA.
- OCIOSO: req_pronto = 1. On req_valido & req_pronto, latch all req_* fields and classify:
  - error (req_tamanho = 11; half with endereco[0] = 1; word with endereco[1:0] != 0; word index >= PROFUNDIDADE) -> RESPOSTA, resp_erro = 1, no RAM access.
  - load -> LEITURA. Word store -> ESCRITA. Sub-word store -> LEITURA.
- LEITURA: mem_re = 1; sample mem_saida at the closing edge. Load: lane-extract (little-endian; byte lane = endereco[1:0], half lane = endereco[1]), extend per req_sinal, register into resp_dado -> RESPOSTA. Store: merge req_dado low byte/half into the sampled word at that lane -> ESCRITA.
- ESCRITA: mem_we = 1, mem_entrada = merged word (or req_dado for word stores); RAM updates at the closing edge -> RESPOSTA.
- RESPOSTA: resp_valido = 1, resp_dado/resp_erro stable; on resp_pronto -> OCIOSO. Held indefinitely while resp_pronto = 0.
- mem_we and mem_re never both high; both 0 outside ESCRITA/LEITURA. mem_endereco holds the latched index from acceptance until the next acceptance.

## Timing
- Reset (rst_n low at a posedge): state OCIOSO; resp_valido, resp_erro, mem_we, mem_re = 0; resp_dado, mem_endereco, mem_entrada = 0; req_pronto = 0 while rst_n low.
- Reset mid-operation aborts: a store still in LEITURA performs no write; a write in ESCRITA during the reset edge is suppressed (mem_we forced 0 while rst_n low).
- Latency, acceptance edge to first resp_valido cycle: load 2 cycles; word store 2; sub-word store 3; error 1.
- No new request is accepted in the RESPOSTA cycle where resp_pronto is sampled; the earliest next acceptance is the following cycle. Throughput: one request per (latency + 1) cycles minimum.
- req_* inputs are ignored when req_pronto = 0; changes after acceptance have no effect.

## Configuration
- UAM_SUBPALAVRA_EN defined: byte/half loads and stores supported as above.
- Undefined: only req_tamanho = 10 is legal; byte/half requests go to RESPOSTA with resp_erro = 1, no RAM access; no read-modify-write path or lane-extract logic is built.

## Test plan
- Reset then word load from 0x0000000C with RAM word 3 = 99 -> mem_re one cycle with mem_endereco = 3; resp_valido 2 cycles after acceptance; resp_dado = 99; resp_erro = 0.
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> single mem_we cycle, mem_endereco = 4; load returns 0xDEADBEEF.
- UAM_SUBPALAVRA_EN: byte store 0xAB to 0x11 over word 0x11223344 -> LEITURA then ESCRITA; word becomes 0x1122AB44; signed byte load 0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half load at 0x13 and word load at 0x1002 (index 1024) -> resp_erro = 1 after 1 cycle, mem_re/mem_we never asserted.
- Hold resp_pronto = 0 for 5 cycles -> resp_valido, resp_dado stable, req_pronto = 0; release -> OCIOSO next cycle.
- Assert rst_n = 0 during ESCRITA of a store to 0x20 -> word 8 unchanged; all outputs at reset values next cycle.

Source files
------------

// File: rtl/unidade_acesso_memoria.sv
// unidade_acesso_memoria: load/store initiator for the data RAM port.
// Takes one byte-addressed request at a time and turns it into word-indexed
// RAM cycles. Sub-word stores are done as read-modify-write.
// Optional feature macro: UAM_SUBPALAVRA_EN (byte/half access). When it is
// not defined, only word accesses are legal and no lane logic is built.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high. The request side is ready only in OCIOSO (and never while rst_n is
// low). The response side keeps valid, data and error stable until the
// consumer raises ready.
module unidade_acesso_memoria #(
  parameter int PROFUNDIDADE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valido,
  output logic        req_pronto,
  input  logic        req_escrita,
  input  logic [1:0]  req_tamanho,
  input  logic        req_sinal,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dado,
  output logic        resp_valido,
  input  logic        resp_pronto,
  output logic [31:0] resp_dado,
  output logic        resp_erro,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_entrada,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_saida,
  output logic [1:0]  estado_dbg
);

  typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, RESPOSTA} estado_t;

  estado_t estado;
  logic    fora_faixa;
  logic    erro_req;
  logic    palavra_escrita;
  logic [31:0] carga;

`ifdef UAM_SUBPALAVRA_EN
  logic        escrita_q;
  logic [1:0]  tamanho_q;
  logic        sinal_q;
  logic [1:0]  lane_q;
  logic [31:0] dado_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] mesclado;
`else
  logic sinal_unused;
  assign sinal_unused = req_sinal;
`endif

  // Out-of-range word index: the upper 30 address bits select the word.
  assign fora_faixa = {2'b00, req_endereco[31:2]} >= 32'(PROFUNDIDADE);

  // Request classification at acceptance time.
  always_comb begin
    erro_req        = fora_faixa;
    palavra_escrita = req_escrita && (req_tamanho == 2'b10);
`ifdef UAM_SUBPALAVRA_EN
    case (req_tamanho)
      2'b00:   erro_req = fora_faixa;
      2'b01:   erro_req = fora_faixa || req_endereco[0];
      2'b10:   erro_req = fora_faixa || (req_endereco[1:0] != 2'b00);
      default: erro_req = 1'b1;
    endcase
`else
    erro_req = fora_faixa || (req_tamanho != 2'b10) || (req_endereco[1:0] != 2'b00);
`endif
  end

`ifdef UAM_SUBPALAVRA_EN
  // Little-endian lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_saida[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_saida[31:16] : mem_saida[15:0];
    case (tamanho_q)
      2'b00:   carga = {{24{sinal_q & byte_sel[7]}}, byte_sel};
      2'b01:   carga = {{16{sinal_q & half_sel[15]}}, half_sel};
      default: carga = mem_saida;
    endcase
    mesclado = mem_saida;
    if (tamanho_q == 2'b00)
      mesclado[{lane_q, 3'b000} +: 8] = dado_q[7:0];
    else
      mesclado[{lane_q[1], 4'b0000} +: 16] = dado_q[15:0];
  end
`else
  assign carga = mem_saida;
`endif

  // Main FSM: state, latched request fields and registered response/RAM fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado       <= OCIOSO;
      resp_dado    <= 32'h0;
      resp_erro    <= 1'b0;
      mem_endereco <= 32'h0;
      mem_entrada  <= 32'h0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (req_valido) begin
`ifdef UAM_SUBPALAVRA_EN
            escrita_q <= req_escrita;
            tamanho_q <= req_tamanho;
            sinal_q   <= req_sinal;
            lane_q    <= req_endereco[1:0];
            dado_q    <= req_dado;
`endif
            mem_endereco <= {2'b00, req_endereco[31:2]};
            mem_entrada  <= req_dado;
            resp_dado    <= 32'h0;
            resp_erro    <= erro_req;
            if (erro_req)             estado <= RESPOSTA;
            else if (palavra_escrita) estado <= ESCRITA;
            else                      estado <= LEITURA;
          end
        end
        LEITURA: begin
`ifdef UAM_SUBPALAVRA_EN
          if (escrita_q) begin
            mem_entrada <= mesclado;
            estado      <= ESCRITA;
          end else begin
            resp_dado <= carga;
            estado    <= RESPOSTA;
          end
`else
          resp_dado <= carga;
          estado    <= RESPOSTA;
`endif
        end
        ESCRITA: estado <= RESPOSTA;
        RESPOSTA: if (resp_pronto) estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Strobes decoded from the state register; the write is killed during reset.
  assign req_pronto  = (estado == OCIOSO) && rst_n;
  assign resp_valido = (estado == RESPOSTA);
  assign mem_re      = (estado == LEITURA);
  assign mem_we      = (estado == ESCRITA) && rst_n;
  assign estado_dbg  = estado;

endmodule
